cpu_clock_ctrl: RTL and testbench
=================================

// Module: cpu_clock_ctrl
// PURPOSE
//  Clock-enable scheduler for the MIPS core, one level above the frequency divider.
//  Issues one-clk cpu_ce pulses in four modes: stop, single-step (debounced button),
//  slow run and fast run. Honours the core's halt request and counts issued core cycles.
//  Sits between the board inputs (switches, buttons) and the core's clock-enable input.
// PARAMETERS
//  SLOW_DIV     25000000  clk cycles between cpu_ce pulses in slow run (period SLOW_DIV+1)
//  FAST_DIV     0         clk cycles between cpu_ce pulses in fast run (0 = every clk)
//  DEBOUNCE     250000    consecutive stable clk cycles needed to accept a step_btn level
// PORTS
//  clk          in   1   system clock; every register is on the rising edge
//  reset        in   1   asynchronous, active-low reset
//  mode         in   2   00 stop, 01 step, 10 slow run, 11 fast run (synchronous level)
//  step_btn     in   1   raw step pushbutton, asynchronous, active-high
//  halt         in   1   halt request from the core, synchronous, active-high
//  resume       in   1   one-clk pulse; leaves HALTED
//  cpu_ce       out  1   one-clk core clock-enable pulse
//  running      out  1   1 while state is RUN
//  halted       out  1   1 while state is HALTED
//  cycle_cnt    out  32  number of cpu_ce pulses issued; wraps to 0 after 2^32-1
// BEHAVIOUR
//  Reset (reset=0): state=STOP, div_cnt=0, cpu_ce=0, running=0, halted=0, cycle_cnt=0.
//    Synchroniser and debouncer are cleared to 0. Reset asserted mid-operation aborts
//    everything immediately, including a pending step or forced pulse.
//  States and transitions:
//   STOP   : no cpu_ce. mode=01 -> STEP; mode=1x -> RUN.
//   STEP   : one cpu_ce per accepted rising edge of the debounced step_btn.
//            mode=00 -> STOP; mode=1x -> RUN.
//   RUN    : div_cnt increments every clk. When div_cnt==DIV, where DIV=SLOW_DIV for
//            mode=10 and FAST_DIV for mode=11: div_cnt<=0 and cpu_ce<=1.
//            mode=00 -> STOP; mode=01 -> STEP.
//   HALTED : no cpu_ce; mode changes are ignored. resume=1 -> issue one forced cpu_ce,
//            then go to the mode-selected state.
//  Halt: when a cpu_ce is due and halt=1, the pulse is suppressed and the next state is
//    HALTED. The forced pulse after resume ignores halt, so the core can pass its halt.
//  Mode-change rule: any change of mode clears div_cnt to 0. The change applies in the
//    next clk cycle.
//  Step input: step_btn passes a 2-FF synchroniser, then the debouncer. The debounced
//    level changes only after DEBOUNCE equal synchronised samples. Only a 0->1 edge
//    counts. An edge seen outside STEP is discarded and is not queued.
//  cpu_ce is registered: it is high exactly one clk per issued pulse and is never
//    high for two consecutive clks unless DIV=0 in fast run.
//  cycle_cnt increments in the same clk in which cpu_ce is high. Unsigned 32-bit wrap.
//  Simultaneous events:
//    - reset beats everything.
//    - halt beats step and divider pulses.
//    - resume with halt=0 still issues one forced pulse.
//    - resume outside HALTED is ignored.
//  running = (state==RUN); halted = (state==HALTED). Both are registered.
// CONFIGURATION
//  CPU_CLK_BREAKPOINT_EN defined:
//    - adds ports: pc (in, 32), bp_addr (in, 32), bp_valid (in, 1), bp_hit (out, 1).
//    - when a cpu_ce is due and bp_valid && pc==bp_addr, the controller behaves exactly
//      as for halt=1, and bp_hit<=1.
//    - bp_hit clears on resume or reset.
//    - the forced resume pulse ignores the breakpoint.
//  CPU_CLK_BREAKPOINT_EN not defined: the ports and logic are absent; behaviour as above.
// TESTING
//  1 Reset:
//    - hold reset=0 with mode=11 and halt=0.
//    - required: cpu_ce=0, cycle_cnt=0, state=STOP.
//    - release reset: the first cpu_ce is high in the 2nd clk after release.
//  2 Fast run, FAST_DIV=0, mode=11, 100 clks:
//    - required: cpu_ce high on every clk and cycle_cnt increments each clk.
//  3 Slow run, SLOW_DIV=4:
//    - required: cpu_ce every 5 clks.
//    - switch mode 10->11 mid-count: div_cnt restarts at 0 and no double pulse occurs.
//  4 Step, DEBOUNCE=8, mode=01:
//    - press with 3-clk glitches, then hold 20 clks: exactly one cpu_ce.
//    - release and press again: a second cpu_ce.
//  5 Halt:
//    - mode=11, raise halt when cycle_cnt=10: no further cpu_ce, halted=1, cycle_cnt=10.
//    - resume pulse: exactly one cpu_ce (cycle_cnt=11), then the run continues once
//      halt=0.
//  6 Wrap:
//    - force cycle_cnt=32'hFFFFFFFF and issue one pulse: cycle_cnt=0.
//    - with CPU_CLK_BREAKPOINT_EN, pc==bp_addr: bp_hit=1 and halted=1.

Source files
------------

// File: rtl/cpu_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cpu_clock_ctrl
// Description : Clock-enable scheduler for the MIPS core. Issues one-clk
//               cpu_ce pulses in stop / single-step / slow-run / fast-run
//               modes, honours the core halt request, counts issued pulses.
//               Optional macro CPU_CLK_BREAKPOINT_EN adds a PC breakpoint.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_clock_ctrl #(
  parameter int unsigned SLOW_DIV = 25000000,
  parameter int unsigned FAST_DIV = 0,
  parameter int unsigned DEBOUNCE = 250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic        step_btn,
  input  logic        halt,
  input  logic        resume,
`ifdef CPU_CLK_BREAKPOINT_EN
  input  logic [31:0] pc,
  input  logic [31:0] bp_addr,
  input  logic        bp_valid,
  output logic        bp_hit,
`endif
  output logic        cpu_ce,
  output logic        running,
  output logic        halted,
  output logic [31:0] cycle_cnt
);

  localparam logic [31:0] c_SLOW_DIV = 32'(SLOW_DIV);
  localparam logic [31:0] c_FAST_DIV = 32'(FAST_DIV);
  localparam int          c_DB_W     = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE - 1);
  localparam logic [c_DB_W-1:0] c_DB_ONE  = c_DB_W'(1);

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_STEP   = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  state_t            w_mode_state;
  logic [31:0]       r_div_cnt;
  logic [31:0]       w_div_next;
  logic [31:0]       w_div_sel;
  logic [1:0]        r_mode_q;
  logic [1:0]        r_sync;
  logic [c_DB_W-1:0] r_db_cnt;
  logic              r_db;
  logic              r_db_prev;
  logic              r_cpu_ce;
  logic              r_running;
  logic              r_halted;
  logic [31:0]       r_cycle_cnt;
  logic              w_ce_next;
  logic              w_mode_chg;
  logic              w_step_rise;
  logic              w_stop_req;
  logic              w_bp_match;
  logic              w_bp_set;
  logic              w_due;

  assign w_mode_chg  = (mode != r_mode_q);
  assign w_step_rise = r_db & ~r_db_prev;
  assign w_div_sel   = mode[0] ? c_FAST_DIV : c_SLOW_DIV;

`ifdef CPU_CLK_BREAKPOINT_EN
  logic r_bp_hit;
  assign w_bp_match = bp_valid && (pc == bp_addr);
  assign bp_hit     = r_bp_hit;
`else
  assign w_bp_match = 1'b0;
`endif
  // A breakpoint match stops the core exactly like a halt request.
  assign w_stop_req = halt | w_bp_match;

  // Map the mode switches onto the state they select.
  always_comb begin
    w_mode_state = ST_RUN;
    case (mode)
      2'b00:   w_mode_state = ST_STOP;
      2'b01:   w_mode_state = ST_STEP;
      default: w_mode_state = ST_RUN;
    endcase
  end

  // Bring the raw pushbutton into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], step_btn};
    end
  end

  // Accept a new button level after DEBOUNCE consecutive differing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db_cnt  <= '0;
      r_db      <= 1'b0;
      r_db_prev <= 1'b0;
    end else begin
      r_db_prev <= r_db;
      if (r_sync[1] == r_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == c_DB_LAST) begin
        r_db     <= r_sync[1];
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + c_DB_ONE;
      end
    end
  end

  // Next state, divider and pulse decision; halt/breakpoint veto any due pulse
  // except the forced pulse that leaves HALTED.
  always_comb begin
    w_state_next = r_state;
    w_div_next   = 32'd0;
    w_ce_next    = 1'b0;
    w_due        = 1'b0;
    w_bp_set     = 1'b0;
    case (r_state)
      ST_STOP: begin
        w_state_next = w_mode_state;
      end
      ST_STEP: begin
        if (w_mode_chg) begin
          w_state_next = w_mode_state;
        end else if (w_step_rise) begin
          w_due = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_mode_chg) begin
          w_state_next = w_mode_state;
        end else if (r_div_cnt == w_div_sel) begin
          w_due = 1'b1;
        end else begin
          w_div_next = r_div_cnt + 32'd1;
        end
      end
      ST_HALTED: begin
        if (resume) begin
          w_ce_next    = 1'b1;
          w_state_next = w_mode_state;
        end
      end
      default: begin
        w_state_next = ST_STOP;
      end
    endcase
    if (w_due) begin
      if (w_stop_req) begin
        w_state_next = ST_HALTED;
        w_bp_set     = w_bp_match;
      end else begin
        w_ce_next = 1'b1;
      end
    end
  end

  // State, divider, registered outputs and the issued-pulse counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_STOP;
      r_div_cnt   <= 32'd0;
      r_mode_q    <= 2'b00;
      r_cpu_ce    <= 1'b0;
      r_running   <= 1'b0;
      r_halted    <= 1'b0;
      r_cycle_cnt <= 32'd0;
    end else begin
      r_state     <= w_state_next;
      r_div_cnt   <= w_div_next;
      r_mode_q    <= mode;
      r_cpu_ce    <= w_ce_next;
      r_running   <= (w_state_next == ST_RUN);
      r_halted    <= (w_state_next == ST_HALTED);
      r_cycle_cnt <= r_cycle_cnt + {31'd0, w_ce_next};
    end
  end

`ifdef CPU_CLK_BREAKPOINT_EN
  // Sticky breakpoint flag, cleared when the core is resumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bp_hit <= 1'b0;
    end else if (w_bp_set) begin
      r_bp_hit <= 1'b1;
    end else if ((r_state == ST_HALTED) && resume) begin
      r_bp_hit <= 1'b0;
    end
  end
`endif

  assign cpu_ce    = r_cpu_ce;
  assign running   = r_running;
  assign halted    = r_halted;
  assign cycle_cnt = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_clock_ctrl
// Description : Directed self-checking bench for cpu_clock_ctrl
//               (SLOW_DIV=4, FAST_DIV=0, DEBOUNCE=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_clock_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic        step_btn;
  logic        halt;
  logic        resume;
  logic        cpu_ce;
  logic        running;
  logic        halted;
  logic [31:0] cycle_cnt;
`ifdef CPU_CLK_BREAKPOINT_EN
  logic [31:0] pc;
  logic [31:0] bp_addr;
  logic        bp_valid;
  logic        bp_hit;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  cpu_clock_ctrl #(
    .SLOW_DIV(4),
    .FAST_DIV(0),
    .DEBOUNCE(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .step_btn  (step_btn),
    .halt      (halt),
    .resume    (resume),
`ifdef CPU_CLK_BREAKPOINT_EN
    .pc        (pc),
    .bp_addr   (bp_addr),
    .bp_valid  (bp_valid),
    .bp_hit    (bp_hit),
`endif
    .cpu_ce    (cpu_ce),
    .running   (running),
    .halted    (halted),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock and settle past the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run n clocks and return how many of them carried cpu_ce.
  task automatic run(input int n, output int ces);
    ces = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (cpu_ce) ces++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc;
    int bad;
    int first;
    int last;
    logic [31:0] prev;

    reset    = 1'b0;
    mode     = 2'b11;
    step_btn = 1'b0;
    halt     = 1'b0;
    resume   = 1'b0;
`ifdef CPU_CLK_BREAKPOINT_EN
    pc       = 32'h0;
    bp_addr  = 32'h0000_0400;
    bp_valid = 1'b0;
`endif

    // Reset held with fast-run mode selected
    repeat (3) @(posedge clk);
    #1;
    check("rst_ce",      32'(cpu_ce),  0);
    check("rst_cnt",     cycle_cnt,    0);
    check("rst_running", 32'(running), 0);
    check("rst_halted",  32'(halted),  0);

    // First pulse lands in the 2nd clk after release
    reset = 1'b1;
    tick();
    check("rel1_ce",      32'(cpu_ce),  0);
    check("rel1_running", 32'(running), 1);
    tick();
    check("rel2_ce",  32'(cpu_ce), 1);
    check("rel2_cnt", cycle_cnt,   1);

    // Halt at cycle_cnt=10
    for (int i = 0; i < 50 && cycle_cnt != 32'd10; i++) tick();
    check("reach_cnt10", cycle_cnt, 10);
    halt = 1'b1;
    tick();
    check("halt_ce",      32'(cpu_ce),  0);
    check("halt_halted",  32'(halted),  1);
    check("halt_running", 32'(running), 0);
    check("halt_cnt",     cycle_cnt,    10);
    mode = 2'b01;
    run(3, n);
    check("halt_mode_ignored_ce", 32'(n),      0);
    check("halt_mode_ignored_st", 32'(halted), 1);
    mode = 2'b11;
    tick();

    // Forced pulse ignores halt, then the core halts again
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("resume_ce",      32'(cpu_ce),  1);
    check("resume_cnt",     cycle_cnt,    11);
    check("resume_running", 32'(running), 1);
    tick();
    check("rehalt_ce",     32'(cpu_ce), 0);
    check("rehalt_halted", 32'(halted), 1);
    check("rehalt_cnt",    cycle_cnt,   11);

    // Resume with halt=0: forced pulse then the run continues
    halt   = 1'b0;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("resume2_cnt", cycle_cnt, 12);
    tick();
    check("run_after_resume_ce",  32'(cpu_ce), 1);
    check("run_after_resume_cnt", cycle_cnt,   13);

    // Fast run, 100 clks
    n = 0;
    bad = 0;
    prev = cycle_cnt;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (cpu_ce) n++;
      if (cycle_cnt != prev + 32'd1) bad++;
      prev = cycle_cnt;
    end
    check("fast_ce_count", 32'(n),   100);
    check("fast_inc_errs", 32'(bad), 0);
    check("fast_cnt",      cycle_cnt, 113);

    // Slow run: mode change edge has no pulse, then one every 5 clks
    mode = 2'b10;
    tick();
    check("slow_chg_ce", 32'(cpu_ce), 0);
    first = -1;
    last  = 0;
    n     = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (cpu_ce) begin
        n++;
        if (first < 0) first = t;
        last = t;
      end
    end
    check("slow_first", 32'(first), 5);
    check("slow_count", 32'(n),     4);
    check("slow_last",  32'(last),  20);
    check("slow_cnt",   cycle_cnt,  117);

    // Switch 10->11 mid-count: divider restarts, no pulse on the change clk
    tick();
    tick();
    mode = 2'b11;
    tick();
    check("switch_ce",  32'(cpu_ce), 0);
    check("switch_cnt", cycle_cnt,   117);
    tick();
    check("switch_next_ce",  32'(cpu_ce), 1);
    check("switch_next_cnt", cycle_cnt,   118);

    // A press seen outside STEP is not queued
    mode = 2'b00;
    tick();
    step_btn = 1'b1;
    run(20, n);
    check("stop_press_ce", 32'(n), 0);
    mode = 2'b01;
    run(5, n);
    check("step_no_queue_ce", 32'(n), 0);
    step_btn = 1'b0;
    run(20, n);
    check("step_release_ce", 32'(n), 0);

    // Glitchy press then hold: exactly one step
    acc = 0;
    for (int g = 0; g < 2; g++) begin
      step_btn = 1'b1;
      run(3, n);
      acc += n;
      step_btn = 1'b0;
      run(3, n);
      acc += n;
    end
    step_btn = 1'b1;
    run(20, n);
    acc += n;
    check("step_press1_ce", 32'(acc), 1);
    step_btn = 1'b0;
    run(20, n);
    check("step_release2_ce", 32'(n), 0);
    step_btn = 1'b1;
    run(20, n);
    check("step_press2_ce", 32'(n), 1);
    check("step_cnt",       cycle_cnt, 120);
    step_btn = 1'b0;
    run(20, n);

    // Wrap of the pulse counter
    mode = 2'b00;
    tick();
    tick();
    force dut.r_cycle_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.r_cycle_cnt;
    tick();
    check("wrap_pre", cycle_cnt, 32'hFFFF_FFFF);
    mode = 2'b10;
    tick();
    run(4, n);
    check("wrap_wait_ce", 32'(n), 0);
    tick();
    check("wrap_ce",  32'(cpu_ce), 1);
    check("wrap_cnt", cycle_cnt,   0);

`ifdef CPU_CLK_BREAKPOINT_EN
    // Breakpoint behaves like halt and sets bp_hit
    pc       = 32'h0000_0400;
    bp_valid = 1'b1;
    mode     = 2'b11;
    tick();
    tick();
    check("bp_hit",    32'(bp_hit), 1);
    check("bp_halted", 32'(halted), 1);
    check("bp_ce",     32'(cpu_ce), 0);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("bp_resume_ce",  32'(cpu_ce), 1);
    check("bp_resume_clr", 32'(bp_hit), 0);
    bp_valid = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
